// File: rtl/hsk_link_watchdog_pkg.sv
// Shared types and timing helpers for the housekeeping link watchdog.
package hsk_wdog_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    NULL_TX = 2'd2,
    HOLD    = 2'd3
  } wdog_state_t;

  // RX low-run length (in clocks) at which a null byte is recognised:
  // half a bit short of the full nine-bit low period, to tolerate edge jitter.
  function automatic int null_th(input int clks_per_bit, input int null_low_bits);
    return null_low_bits * clks_per_bit - clks_per_bit / 2;
  endfunction

  // RX low-run length (in clocks) beyond which the line is considered in break.
  function automatic int brk_th(input int clks_per_bit, input int null_low_bits);
    return (null_low_bits + 1) * clks_per_bit;
  endfunction

  // Number of clocks the TX line is held low for a transmitted null byte.
  function automatic int tx_len(input int clks_per_bit, input int null_low_bits);
    return null_low_bits * clks_per_bit;
  endfunction

endpackage

// File: rtl/hsk_link_watchdog_if.sv
// Monitor/control bundle between the clock monitors, software and the watchdog.
interface hsk_wdog_if #(
  parameter int NUM_MON = 8,
  parameter int CNT_W   = 16
);
  logic [NUM_MON-1:0] ok_i;
  logic [NUM_MON-1:0] mask_i;
  logic               enable_i;
  logic               clear_i;
  logic               hsk_rx_i;
  logic               trigger_o;
  logic               null_o;
  logic [NUM_MON-1:0] lost_o;
  logic               rx_null_o;
  logic               rx_break_o;
  logic [CNT_W-1:0]   null_count_o;
  logic [1:0]         state_o;

  // Driver side (status sources and software).
  modport master (
    output ok_i, mask_i, enable_i, clear_i, hsk_rx_i,
    input  trigger_o, null_o, lost_o, rx_null_o, rx_break_o, null_count_o, state_o
  );

  // Watchdog side.
  modport slave (
    input  ok_i, mask_i, enable_i, clear_i, hsk_rx_i,
    output trigger_o, null_o, lost_o, rx_null_o, rx_break_o, null_count_o, state_o
  );
endinterface

// File: rtl/hsk_link_watchdog_low_run_det.sv
// Housekeeping RX low-run detector: flags null bytes and line breaks.
module hsk_low_run_det
  import hsk_wdog_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 400,
  parameter int NULL_LOW_BITS = 9
) (
  input  logic wb_clk_i,
  input  logic rst_n,
  input  logic hsk_rx_i,
  output logic rx_null_o,
  output logic rx_break_o
);

  localparam int NULL_TH = null_th(CLKS_PER_BIT, NULL_LOW_BITS);
  localparam int BRK_TH  = brk_th(CLKS_PER_BIT, NULL_LOW_BITS);
  localparam int RUN_W   = $clog2(BRK_TH + 1);

  localparam logic [RUN_W-1:0] NULL_V = RUN_W'(NULL_TH);
  localparam logic [RUN_W-1:0] BRK_V  = RUN_W'(BRK_TH);

  logic [RUN_W-1:0] run_q, run_d;

  // Count consecutive low cycles; saturating at the break threshold keeps the
  // null threshold from being crossed twice within one long low period.
  always_comb begin
    run_d = run_q;
    if (hsk_rx_i) begin
      run_d = '0;
    end else if (run_q != BRK_V) begin
      run_d = run_q + RUN_W'(1);
    end
  end

  // Low-run counter register.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  // The counter passes through NULL_TH at most once per low period.
  assign rx_null_o  = (run_q == NULL_V);
  assign rx_break_o = (run_q == BRK_V);

endmodule

// File: rtl/hsk_link_watchdog.sv
// Housekeeping link watchdog: arms on healthy masked clock-OK bits, sends a
// timed null byte on a masked OK drop, then holds until software clears it.
module hsk_link_watchdog
  import hsk_wdog_pkg::*;
#(
  parameter int NUM_MON       = 8,
  parameter int CLKS_PER_BIT  = 400,
  parameter int NULL_LOW_BITS = 9,
  parameter int CNT_W         = 16
) (
  input  logic      wb_clk_i,
  input  logic      wb_rst_n_i,
  hsk_wdog_if.slave bus
);

  localparam int TX_LEN = tx_len(CLKS_PER_BIT, NULL_LOW_BITS);
  localparam int TMR_W  = $clog2(TX_LEN + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TX_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (CLKS_PER_BIT < 2 || NUM_MON < 1 || NUM_MON > 32) begin : g_bad_params
    $error("hsk_link_watchdog: CLKS_PER_BIT must be >= 2 and NUM_MON in 1..32");
  end

  logic [1:0]         rst_sync_q;
  logic               rst_n;
  logic [NUM_MON-1:0] ok_q;
  logic [NUM_MON-1:0] fall;
  logic [NUM_MON-1:0] lost_q, lost_d;
  wdog_state_t        state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               null_q, null_d;
  logic               trig_q, trig_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rx_null;
  logic               rx_break;

  // Reset synchroniser: assertion is immediate, release waits two clocks.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  assign fall = ok_q & ~bus.ok_i;

  // Watchdog next-state, null timer, sticky flags and RX null counter.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        // An all-zero mask would trivially satisfy the health check; refuse it.
        if (bus.enable_i && (|bus.mask_i) && (&(bus.ok_i | ~bus.mask_i))) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (|(fall & bus.mask_i)) begin
          state_d = NULL_TX;
          timer_d = '0;
        end else if (!bus.enable_i) begin
          state_d = IDLE;
        end
      end
      NULL_TX: begin
        if (timer_q == TMR_LAST) begin
          state_d = HOLD;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HOLD: begin
        if (bus.clear_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    null_d = (state_d == NULL_TX);
    trig_d = (state_d == NULL_TX) || (state_d == HOLD);

    // A drop coinciding with a clear must not be lost.
    lost_d = (lost_q & ~{NUM_MON{bus.clear_i}}) | fall;

    count_d = count_q;
    if (bus.clear_i) begin
      count_d = '0;
    end else if (rx_null && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State and status registers; ok_q starts high so reset never fakes a drop.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ok_q    <= '1;
      lost_q  <= '0;
      state_q <= IDLE;
      timer_q <= '0;
      null_q  <= 1'b0;
      trig_q  <= 1'b0;
      count_q <= '0;
    end else begin
      ok_q    <= bus.ok_i;
      lost_q  <= lost_d;
      state_q <= state_d;
      timer_q <= timer_d;
      null_q  <= null_d;
      trig_q  <= trig_d;
      count_q <= count_d;
    end
  end

  hsk_low_run_det #(
    .CLKS_PER_BIT  (CLKS_PER_BIT),
    .NULL_LOW_BITS (NULL_LOW_BITS)
  ) u_low_run_det (
    .wb_clk_i   (wb_clk_i),
    .rst_n      (rst_n),
    .hsk_rx_i   (bus.hsk_rx_i),
    .rx_null_o  (rx_null),
    .rx_break_o (rx_break)
  );

  assign bus.trigger_o    = trig_q;
  assign bus.null_o       = null_q;
  assign bus.lost_o       = lost_q;
  assign bus.rx_null_o    = rx_null;
  assign bus.rx_break_o   = rx_break;
  assign bus.null_count_o = count_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_hsk_link_watchdog.sv
// Self-checking bench for hsk_link_watchdog: default-parameter instance for
// the directed/table checks, a small instance for saturation and random runs.
module tb_hsk_link_watchdog;

  localparam int NM_A = 8;
  localparam int NM_B = 4;
  localparam int CW_B = 2;
  // Expected timing constants derived by hand from the bit-time rules.
  localparam int L_A    = 9 * 400;                // 3600
  localparam int NTH_A  = 9 * 400 - 200;          // 3400
  localparam int BRK_A  = 10 * 400;               // 4000
  localparam int L_B    = 9 * 4;                  // 36
  localparam int NTH_B  = 9 * 4 - 2;              // 34
  localparam int BRK_B  = 10 * 4;                 // 40
  localparam int CMAX_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hsk_wdog_if #(.NUM_MON(NM_A), .CNT_W(16))   if_a ();
  hsk_wdog_if #(.NUM_MON(NM_B), .CNT_W(CW_B)) if_b ();

  hsk_link_watchdog #(.NUM_MON(NM_A), .CLKS_PER_BIT(400), .NULL_LOW_BITS(9), .CNT_W(16)) dut_a (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (if_a.slave)
  );

  hsk_link_watchdog #(.NUM_MON(NM_B), .CLKS_PER_BIT(4), .NULL_LOW_BITS(9), .CNT_W(CW_B)) dut_b (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (if_b.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  // Hold RX low for len cycles, then release; report pulses and break timing.
  task automatic rx_run(input int len, output int pulses, output int brk_first, output int brk_after);
    pulses    = 0;
    brk_first = -1;
    if_a.hsk_rx_i = 1'b0;
    for (int i = 1; i <= len; i++) begin
      tick();
      if (if_a.rx_null_o === 1'b1) pulses++;
      if (if_a.rx_break_o === 1'b1 && brk_first < 0) brk_first = i;
    end
    if_a.hsk_rx_i = 1'b1;
    tick();
    brk_after = int'(if_a.rx_break_o);
    if (if_a.rx_null_o === 1'b1) pulses++;
    repeat (2) begin
      tick();
      if (if_a.rx_null_o === 1'b1) pulses++;
    end
  endtask

  typedef struct {
    logic [7:0] ok;
    logic [7:0] mask;
    logic       en;
    logic       clr;
    logic [1:0] st;
    logic [7:0] lost;
  } vec_t;

  vec_t tbl[11];

  // Reference model for the random run (instance B)
  logic [3:0] m_okprev, m_lost;
  int m_phase, m_left, m_run, m_cnt;

  task automatic model_step(input logic [3:0] ok, input logic [3:0] mask, input logic en,
                            input logic clr, input logic rx);
    logic [3:0] f;
    f = m_okprev & ~ok;
    case (m_phase)
      0: if (en && mask != 4'h0 && ((ok | ~mask) == 4'hF)) m_phase = 1;
      1: begin
        if ((f & mask) != 4'h0) begin
          m_phase = 2;
          m_left  = L_B;
        end else if (!en) begin
          m_phase = 0;
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) m_phase = 3;
      end
      default: if (clr) m_phase = 0;
    endcase
    m_lost = (clr ? 4'h0 : m_lost) | f;
    if (clr) m_cnt = 0;
    else if (m_run == NTH_B && m_cnt < CMAX_B) m_cnt++;
    m_run = rx ? 0 : m_run + 1;
    m_okprev = ok;
  endtask

  initial begin
    int n, p, bf, ba;
    logic [3:0] okv, mskv;
    logic       env, clrv, rxl;
    int         rx_left;
    logic [31:0] act, exp;

    tbl[0]  = '{8'hFF, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{8'hFF, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00};
    tbl[2]  = '{8'hFE, 8'h01, 1'b1, 1'b0, 2'd0, 8'h01};
    tbl[3]  = '{8'hFE, 8'h01, 1'b1, 1'b1, 2'd0, 8'h00};
    tbl[4]  = '{8'hFF, 8'h01, 1'b1, 1'b0, 2'd1, 8'h00};
    tbl[5]  = '{8'hF7, 8'h01, 1'b1, 1'b0, 2'd1, 8'h08};
    tbl[6]  = '{8'hF7, 8'h01, 1'b1, 1'b1, 2'd1, 8'h00};
    tbl[7]  = '{8'hFF, 8'h01, 1'b1, 1'b0, 2'd1, 8'h00};
    tbl[8]  = '{8'hF7, 8'h01, 1'b1, 1'b1, 2'd1, 8'h08};
    tbl[9]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 2'd0, 8'h08};
    tbl[10] = '{8'hFF, 8'h01, 1'b1, 1'b1, 2'd1, 8'h00};

    if_a.ok_i = '1; if_a.mask_i = '0; if_a.enable_i = 1'b0; if_a.clear_i = 1'b0; if_a.hsk_rx_i = 1'b1;
    if_b.ok_i = '1; if_b.mask_i = '0; if_b.enable_i = 1'b0; if_b.clear_i = 1'b0; if_b.hsk_rx_i = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_state", 32'(if_a.state_o), 0);
    chk("rst_trig",  32'(if_a.trigger_o), 0);
    chk("rst_null",  32'(if_a.null_o), 0);
    chk("rst_lost",  32'(if_a.lost_o), 0);
    chk("rst_rx",    32'({if_a.rx_null_o, if_a.rx_break_o}), 0);
    chk("rst_count", 32'(if_a.null_count_o), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_state", 32'(if_a.state_o), 0);

    // Arm / mask / sticky-flag vectors
    for (int i = 0; i < 11; i++) begin
      if_a.ok_i = tbl[i].ok; if_a.mask_i = tbl[i].mask;
      if_a.enable_i = tbl[i].en; if_a.clear_i = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d_state", i), 32'(if_a.state_o), 32'(tbl[i].st));
      chk($sformatf("vec%0d_lost", i),  32'(if_a.lost_o),  32'(tbl[i].lost));
      chk($sformatf("vec%0d_trig", i),  32'(if_a.trigger_o), 0);
    end
    if_a.clear_i = 1'b0;

    // Masked drop -> timed null, clear/enable ignored during it
    if_a.ok_i = 8'hFE;
    tick();
    chk("trig_state", 32'(if_a.state_o), 2);
    chk("trig_null",  32'(if_a.null_o), 1);
    chk("trig_trig",  32'(if_a.trigger_o), 1);
    chk("trig_lost",  32'(if_a.lost_o), 32'h01);
    n = 1;
    while (if_a.null_o === 1'b1 && n < 5000) begin
      if_a.clear_i  = (n == 100);
      if_a.enable_i = (n < 100);
      if_a.ok_i     = (n >= 200) ? 8'hDE : 8'hFE;
      tick();
      if (if_a.null_o === 1'b1) n++;
    end
    if_a.clear_i = 1'b0;
    chk("null_len",   32'(n), 32'(L_A));
    chk("hold_state", 32'(if_a.state_o), 3);
    chk("hold_trig",  32'(if_a.trigger_o), 1);
    chk("hold_lost",  32'(if_a.lost_o), 32'h20);
    if_a.enable_i = 1'b1; if_a.ok_i = 8'hFF;
    repeat (5) tick();
    chk("hold_stays", 32'(if_a.state_o), 3);
    if_a.clear_i = 1'b1;
    tick();
    if_a.clear_i = 1'b0;
    chk("hold_clr_state", 32'(if_a.state_o), 0);
    chk("hold_clr_trig",  32'(if_a.trigger_o), 0);
    chk("hold_clr_lost",  32'(if_a.lost_o), 0);
    tick();
    chk("rearm_state", 32'(if_a.state_o), 1);

    // RX null / break detection
    rx_run(NTH_A - 1, p, bf, ba);
    chk("rx3399_pulses", 32'(p), 0);
    chk("rx3399_count",  32'(if_a.null_count_o), 0);
    rx_run(NTH_A, p, bf, ba);
    chk("rx3400_pulses", 32'(p), 1);
    chk("rx3400_brk",    32'(bf), 32'(-1));
    chk("rx3400_count",  32'(if_a.null_count_o), 1);
    rx_run(5000, p, bf, ba);
    chk("rx5000_pulses",   32'(p), 1);
    chk("rx5000_brkfirst", 32'(bf), 32'(BRK_A));
    chk("rx5000_brkafter", 32'(ba), 0);
    chk("rx5000_count",    32'(if_a.null_count_o), 2);
    if_a.clear_i = 1'b1;
    tick();
    if_a.clear_i = 1'b0;
    chk("count_clr", 32'(if_a.null_count_o), 0);
    // Clear on the same edge as the increment: clear wins
    if_a.hsk_rx_i = 1'b0;
    repeat (NTH_A) tick();
    if_a.hsk_rx_i = 1'b1; if_a.clear_i = 1'b1;
    tick();
    if_a.clear_i = 1'b0;
    tick();
    chk("count_clr_wins", 32'(if_a.null_count_o), 0);

    // Disable and trigger on the same edge -> trigger wins
    chk("pre_dis_state", 32'(if_a.state_o), 1);
    if_a.ok_i = 8'hFE; if_a.enable_i = 1'b0;
    tick();
    chk("dis_trig_state", 32'(if_a.state_o), 2);

    // Reset in the middle of the null
    repeat (999) tick();
    chk("mid_null", 32'(if_a.null_o), 1);
    #2;
    rst_n = 1'b0;
    if_a.ok_i = 8'hFF;
    #1;
    chk("async_null",  32'(if_a.null_o), 0);
    chk("async_trig",  32'(if_a.trigger_o), 0);
    chk("async_state", 32'(if_a.state_o), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rel_state", 32'(if_a.state_o), 0);
    chk("rel_lost",  32'(if_a.lost_o), 0);
    chk("rel_null",  32'(if_a.null_o), 0);

    // Small instance: counter saturation
    for (int k = 1; k <= 4; k++) begin
      if_b.hsk_rx_i = 1'b0;
      repeat (NTH_B) tick();
      if_b.hsk_rx_i = 1'b1;
      repeat (2) tick();
      chk($sformatf("sat_count%0d", k), 32'(if_b.null_count_o), 32'((k < CMAX_B) ? k : CMAX_B));
    end

    // Small instance: randomized run against the reference model
    do_reset();
    m_okprev = 4'hF; m_lost = 4'h0; m_phase = 0; m_left = 0; m_run = 0; m_cnt = 0;
    okv = 4'hF; mskv = 4'h3; env = 1'b1; rxl = 1'b1; rx_left = 3;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < NM_B; b++)
        if (!okv[b] && $urandom_range(0, 3) == 0) okv[b] = 1'b1;
      if ($urandom_range(0, 15) == 0) okv[$urandom_range(0, NM_B - 1)] = 1'b0;
      if ($urandom_range(0, 255) == 0) mskv = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) env = ~env;
      clrv = ($urandom_range(0, 31) == 0);
      if (rx_left == 0) begin
        rxl = ~rxl;
        rx_left = rxl ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 46));
      end
      rx_left--;
      if_b.ok_i = okv; if_b.mask_i = mskv; if_b.enable_i = env;
      if_b.clear_i = clrv; if_b.hsk_rx_i = rxl;
      model_step(okv, mskv, env, clrv, rxl);
      tick();
      act = 32'({if_b.state_o, if_b.null_o, if_b.trigger_o, if_b.lost_o,
                 if_b.rx_null_o, if_b.rx_break_o, if_b.null_count_o});
      exp = 32'({2'(m_phase), (m_phase == 2), (m_phase >= 2), m_lost,
                 (m_run == NTH_B), (m_run >= BRK_B), 2'(m_cnt)});
      chk($sformatf("rand_c%0d", c), act, exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hsk_link_watchdog.md
Name: hsk_link_watchdog

Overview:
Parametrised successor to the single-purpose housekeeping watchdog logic in the SURF ID/control block. It monitors NUM_MON clock-OK status bits, each individually maskable. A masked OK bit dropping after the link was healthy triggers a watchdog. The watchdog then drives a timed null byte onto the housekeeping TX line and holds the trigger until software clears it. In parallel it detects incoming null bytes and breaks on the housekeeping RX line, counting nulls. It sits between simple_clock_mon outputs and the housekeeping UART path, entirely in the wishbone clock domain.

Parameters:
NUM_MON, 8, number of monitored OK inputs (1..32)
CLKS_PER_BIT, 400, wb_clk cycles per housekeeping bit (e.g. 200 MHz at 500 kbps)
NULL_LOW_BITS, 9, bit times the line is low for a null byte (start bit + 8 data bits)
CNT_W, 16, width of the RX null counter

Ports:
wb_clk_i  in  1  wishbone/system clock; the only clock
wb_rst_n_i  in  1  asynchronous active-low reset
ok_i  in  NUM_MON  clock-OK levels, already in the wb_clk_i domain
mask_i  in  NUM_MON  1 = this OK bit participates in arm/trigger
enable_i  in  1  watchdog enable (level)
clear_i  in  1  one-cycle pulse: clear sticky flags, release HOLD
hsk_rx_i  in  1  housekeeping RX line (idle high)
trigger_o  out  1  watchdog triggered (level)
null_o  out  1  1 = force housekeeping TX low
lost_o  out  NUM_MON  sticky per-bit OK-dropped flags
rx_null_o  out  1  one-cycle pulse per detected RX null
rx_break_o  out  1  RX low longer than a null (level)
null_count_o  out  CNT_W  saturating count of RX nulls
state_o  out  2  FSM state encoding

Behaviour:
- Reset (async assert, sync release via 2-flop synchroniser on wb_rst_n_i): state IDLE; all outputs 0; ok_q <= all 1s (no false edge after reset).
- ok_q registers ok_i each cycle. fall[k] = ok_q[k] & ~ok_i[k].
- lost_o[k]: set on fall[k] regardless of mask/enable; cleared by clear_i. Simultaneous set and clear: set wins.
- FSM (state_o: IDLE=0, ARMED=1, NULL_TX=2, HOLD=3):
  - IDLE -> ARMED when enable_i & ((ok_i | ~mask_i) all 1). mask_i == 0 never arms.
  - ARMED -> IDLE if !enable_i.
  - ARMED -> NULL_TX if any (fall & mask_i). Trigger takes priority over a same-cycle disable.
  - NULL_TX: null_o = 1 for exactly NULL_LOW_BITS*CLKS_PER_BIT cycles, starting the cycle after the trigger edge. Then -> HOLD. enable_i and clear_i are ignored in NULL_TX.
  - HOLD: null_o = 0 (line returns high = stop bit/idle). HOLD -> IDLE on clear_i.
  - trigger_o = 1 in NULL_TX and HOLD, registered. It rises on the same cycle null_o rises.
- Further falls while in NULL_TX/HOLD only update lost_o; the null is never restarted.
- RX detector: low-run counter counts consecutive cycles with hsk_rx_i = 0. It resets to 0 on hsk_rx_i = 1 and saturates at BRK_TH.
  - NULL_TH = NULL_LOW_BITS*CLKS_PER_BIT - CLKS_PER_BIT/2 (3400 at defaults).
  - BRK_TH = (NULL_LOW_BITS+1)*CLKS_PER_BIT (4000).
  - rx_null_o pulses once, on the cycle the counter equals NULL_TH. A break run also produces exactly one pulse.
  - rx_break_o goes high when the counter reaches BRK_TH and stays high until hsk_rx_i = 1 (deasserts the cycle after).
- null_count_o increments on rx_null_o and saturates at 2^CNT_W-1. It is cleared by clear_i; a same-cycle increment is lost (clear wins).
- Width rules: timer width = $clog2(NULL_LOW_BITS*CLKS_PER_BIT+1); low-run width = $clog2(BRK_TH+1). Elaboration fails if CLKS_PER_BIT < 2 or NUM_MON > 32.

Decomposition:
- Package hsk_wdog_pkg: state enum wdog_state_t (IDLE/ARMED/NULL_TX/HOLD, 2-bit) and constant functions null_th(), brk_th(), tx_len(), each taking CLKS_PER_BIT and NULL_LOW_BITS.
- Sub-module hsk_low_run_det: low-run counter, rx_null_o pulse, rx_break_o.
- Top contains the FSM, the sticky flags and the counter.

Test Plan:
- Default params; mask_i=8'h01, enable_i=1, all ok_i=1 -> state ARMED after 1 cycle. Drop ok_i[0] -> trigger_o and null_o rise next cycle; null_o high exactly 3600 cycles; then state HOLD, null_o=0, trigger_o=1.
- ARMED, drop unmasked ok_i[3] -> lost_o=8'h08, no trigger; clear_i -> lost_o=0 while state stays ARMED. Same-cycle fall of ok_i[3] with clear_i -> lost_o[3]=1.
- hsk_rx_i low 3399 cycles -> no pulse. Low 3400 -> one rx_null_o pulse, null_count_o=1. Low 5000 -> one pulse total; rx_break_o high from cycle 4000 until the line returns high.
- mask_i=0 with enable_i=1 -> stays IDLE forever. Any masked ok_i low at enable -> stays IDLE until that ok_i rises.
- Reset asserted mid-NULL_TX (cycle 1000) -> null_o and trigger_o go 0 asynchronously; state IDLE after release; no lost_o set from ok_q reinit.
- CNT_W=2, four nulls -> null_count_o reads 1,2,3,3 (saturates). Disable and trigger in the same cycle in ARMED -> enters NULL_TX.
